bus_arbiter8: RTL and testbench
===============================

Name: bus_arbiter8

Overview:
- Round-robin arbiter/scheduler that shares one CPU-side resource (shared bus / register-file write port) among 8 requesters.
- Selects one owner and drives a registered one-hot grant, in the same one-hot format as the 3-to-8 decoder output, plus the owner's 3-bit index.
- Holds the grant until the owner releases it or a hold timeout expires, then inserts a programmable idle gap before re-arbitrating.

Parameters:
- HOLD_MAX, 16, max cycles one owner may hold grant before forced release; legal 1..255.
- GAP_CYCLES, 1, cycles of grant=0 between consecutive owners; legal 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  8  request per requester; bit i = requester i.
- done  input  1  current owner releases the resource; sampled only in OWN.
- grant  output  8  registered one-hot grant; all-zero when no owner.
- grant_id  output  3  index of current owner; valid only when grant_valid=1.
- grant_valid  output  1  high while any grant bit is set.
- timeout  output  1  one-cycle pulse when the owner is force-released by HOLD_MAX.

Behaviour:
- Reset (async, immediate, including mid-ownership):
  - grant=0, grant_id=0, grant_valid=0, timeout=0.
  - state=IDLE, hold_cnt=0, gap_cnt=0, last_id=7, so requester 0 has first priority.
- States: IDLE, OWN, GAP. All outputs are registered.
- Arbitration function:
  - Scan req from (last_id+1) mod 8 upward, wrapping 7->0.
  - The first set bit wins.
  - grant = one-hot of the winner; grant_id = winner.
- IDLE:
  - At a clk edge with req!=0: go to OWN, load grant/grant_id, grant_valid=1, hold_cnt=0.
  - Latency: req high before edge k -> grant visible after edge k (1 cycle).
  - With req==0: stay in IDLE, outputs remain zero.
- OWN: hold_cnt increments each cycle. A release occurs at an edge when any of these holds:
  - (a) done=1;
  - (b) req[grant_id]=0;
  - (c) hold_cnt==HOLD_MAX-1.
- On release:
  - grant=0, grant_valid=0, last_id=grant_id, gap_cnt=0, go to GAP.
  - timeout=1 for one cycle only if (c) alone caused the release.
  - If (c) coincides with (a) or (b), timeout=0.
- In OWN, req from non-owners is ignored; the owner cannot be preempted.
- GAP:
  - grant stays 0 for exactly GAP_CYCLES cycles; gap_cnt increments.
  - At the edge where gap_cnt==GAP_CYCLES-1:
    - req!=0: arbitrate and go directly to OWN.
    - req==0: go to IDLE.
  - The previous owner is lowest priority at that point because last_id was just updated.
- Fairness:
  - With all 8 requesting continuously, grants rotate 0,1,...,7,0,...
  - Each requester waits at most 7 tenures.
- Invariants:
  - grant is always zero or one-hot.
  - grant_valid == |grant.
  - grant_id matches the grant bit whenever grant_valid=1.
  - timeout never asserts while grant_valid=1 for the same cycle's new owner.
- Counter widths: hold_cnt 8 bits, gap_cnt 4 bits, no wrap in legal parameter range.

Test Plan:
- Single requester: reset, req=8'h04 held, done pulsed 3 cycles after grant.
  - Required: grant=8'h04, grant_id=2 one cycle after req.
  - Required: grant=0 after done; 1 gap cycle; then grant=8'h04 again (only requester).
- Rotation/wrap: req=8'hFF constant, done pulsed every grant.
  - Required: grant_id sequence 0,1,2,3,4,5,6,7,0 with 1 zero-grant cycle between each.
- Priority pointer: last owner 5, then req=8'h21 (bits 0 and 5).
  - Required: grant=8'h01 (index 0 is next after 5 wrapping, beats 5).
- Timeout: HOLD_MAX=16, req=8'h80 held, done=0.
  - Required: grant=8'h80 for exactly 16 cycles, then grant=0 with timeout=1 for 1 cycle.
  - Done asserted in the 16th cycle -> timeout stays 0.
- Request drop: owner 3 deasserts req[3] while req[6]=1.
  - Required: grant=0 next edge, one gap cycle, then grant=8'h40, grant_id=6.
- Reset mid-ownership: assert reset while grant=8'h10.
  - Required: grant/grant_valid=0 immediately without waiting for a clk edge.
  - After reset release with req=8'h10: grant=8'h10 after the first edge, since last_id=7 gives index 0 priority and index 4 is the first set bit.

Source files
------------

// File: rtl/bus_arbiter8.sv
// Round-robin arbiter sharing one resource among 8 requesters.
// Registered one-hot grant with hold timeout and a programmable idle gap between owners.
module bus_arbiter8 #(
    parameter int HOLD_MAX   = 16,
    parameter int GAP_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] grant,
    output logic [2:0] grant_id,
    output logic       grant_valid,
    output logic       timeout
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_OWN  = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
    localparam logic [3:0] GAP_LAST  = 4'(GAP_CYCLES - 1);

    logic [1:0] r_state;
    logic [7:0] r_grant;
    logic [2:0] r_grant_id;
    logic       r_grant_valid;
    logic       r_timeout;
    logic [7:0] r_hold_cnt;
    logic [3:0] r_gap_cnt;
    logic [2:0] r_last_id;

    logic       w_found;
    logic [2:0] w_win_id;
    logic [2:0] w_idx;
    logic       w_rel_done;
    logic       w_rel_drop;
    logic       w_rel_hold;
    logic       w_release;
    logic       w_to_only;

    // Scan starts just past the last owner; k=8 wraps back to the last owner itself,
    // so it is considered only after every other requester.
    always_comb begin
        w_found  = 1'b0;
        w_win_id = 3'd0;
        w_idx    = 3'd0;
        for (int k = 1; k <= 8; k++) begin
            w_idx = r_last_id + 3'(k);
            if (!w_found && req[w_idx]) begin
                w_found  = 1'b1;
                w_win_id = w_idx;
            end
        end
    end

    assign w_rel_done = done;
    assign w_rel_drop = !req[r_grant_id];
    assign w_rel_hold = (r_hold_cnt == HOLD_LAST);
    assign w_release  = w_rel_done || w_rel_drop || w_rel_hold;
    assign w_to_only  = w_rel_hold && !w_rel_done && !w_rel_drop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_grant       <= 8'd0;
            r_grant_id    <= 3'd0;
            r_grant_valid <= 1'b0;
            r_timeout     <= 1'b0;
            r_hold_cnt    <= 8'd0;
            r_gap_cnt     <= 4'd0;
            r_last_id     <= 3'd7;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_state       <= S_OWN;
                        r_grant       <= 8'd1 << w_win_id;
                        r_grant_id    <= w_win_id;
                        r_grant_valid <= 1'b1;
                        r_hold_cnt    <= 8'd0;
                    end
                end
                S_OWN: begin
                    // Non-owner requests are ignored here: no preemption.
                    if (w_release) begin
                        r_state       <= S_GAP;
                        r_grant       <= 8'd0;
                        r_grant_id    <= 3'd0;
                        r_grant_valid <= 1'b0;
                        r_last_id     <= r_grant_id;
                        r_gap_cnt     <= 4'd0;
                        r_timeout     <= w_to_only;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 8'd1;
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        if (w_found) begin
                            r_state       <= S_OWN;
                            r_grant       <= 8'd1 << w_win_id;
                            r_grant_id    <= w_win_id;
                            r_grant_valid <= 1'b1;
                            r_hold_cnt    <= 8'd0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 4'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign grant       = r_grant;
    assign grant_id    = r_grant_id;
    assign grant_valid = r_grant_valid;
    assign timeout     = r_timeout;

endmodule

// File: tb/tb_bus_arbiter8.sv
// Directed + randomized bench for bus_arbiter8 against a tenure-level reference model.
module tb_bus_arbiter8;

    localparam int HOLD = 16;
    localparam int GAP  = 1;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] req;
    logic       done;
    logic [7:0] grant;
    logic [2:0] grant_id;
    logic       grant_valid;
    logic       timeout;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: who owns, how long they have held, gap cycles left, last owner.
    int m_owner, m_held, m_gap_left, m_last;
    bit m_to;

    bus_arbiter8 #(.HOLD_MAX(HOLD), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .reset(reset), .req(req), .done(done),
        .grant(grant), .grant_id(grant_id), .grant_valid(grant_valid), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [7:0] r, input int last);
        for (int k = 1; k <= 8; k++)
            if (r[(last + k) % 8]) return (last + k) % 8;
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_held = 0; m_gap_left = 0; m_last = 7; m_to = 0;
    endtask

    // Advance the model by one clock edge using the inputs present before that edge.
    task automatic model_step();
        bit rd, rq, rh;
        m_to = 0;
        if (m_owner >= 0) begin
            m_held++;
            rd = done; rq = !req[m_owner]; rh = (m_held == HOLD);
            if (rd || rq || rh) begin
                m_to = rh && !rd && !rq;
                m_last = m_owner;
                m_owner = -1;
                m_gap_left = GAP;
            end
        end else if (m_gap_left > 1) begin
            m_gap_left--;
        end else begin
            m_gap_left = 0;
            m_owner = pick(req, m_last);
            m_held = 0;
        end
    endtask

    task automatic check_model(input string tag);
        logic [7:0] eg;
        eg = (m_owner >= 0) ? (8'd1 << m_owner) : 8'd0;
        chk({tag, ".grant"}, 32'(grant), 32'(eg));
        chk({tag, ".valid"}, 32'(grant_valid), 32'(m_owner >= 0));
        chk({tag, ".id"}, 32'(grant_id), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
        chk({tag, ".timeout"}, 32'(timeout), 32'(m_to));
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check_model("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int n80;
        bit seen_to;
        req = 8'h00; done = 1'b0; reset = 1'b0;
        model_reset();
        #2;
        do_reset();

        // Single requester 2
        req = 8'h04;
        tick("single.grant");
        chk("single.grant_val", 32'(grant), 32'h04);
        chk("single.grant_id", 32'(grant_id), 32'd2);
        tick("single.hold1");
        tick("single.hold2");
        done = 1'b1;
        tick("single.release");
        chk("single.released", 32'(grant), 32'h0);
        done = 1'b0;
        tick("single.regrant");
        chk("single.regrant_val", 32'(grant), 32'h04);
        req = 8'h00;
        tick("single.drop");
        tick("single.idle");

        // Rotation with all requesting
        do_reset();
        req = 8'hFF;
        tick("rot.first");
        for (int i = 0; i < 8; i++) begin
            chk("rot.id", 32'(grant_id), 32'(i));
            done = 1'b1;
            tick("rot.release");
            chk("rot.gap", 32'(grant), 32'h0);
            done = 1'b0;
            tick("rot.next");
        end
        chk("rot.wrap", 32'(grant_id), 32'd0);

        // Priority pointer after owner 5
        do_reset();
        req = 8'h20;
        tick("prio.own5");
        done = 1'b1;
        tick("prio.rel5");
        done = 1'b0;
        req = 8'h21;
        tick("prio.next");
        chk("prio.wins0", 32'(grant), 32'h01);
        req = 8'h00;
        tick("prio.drop");
        tick("prio.idle");

        // Timeout: owner holds with no done
        req = 8'h80;
        tick("to.grant");
        n80 = (grant == 8'h80) ? 1 : 0;
        seen_to = 0;
        for (int c = 0; c < 40 && !seen_to; c++) begin
            tick("to.hold");
            if (grant == 8'h80) n80++;
            if (timeout) begin
                seen_to = 1;
                chk("to.grant_zero", 32'(grant), 32'h0);
            end
        end
        chk("to.seen", 32'(seen_to), 32'd1);
        chk("to.len", 32'(n80), 32'd16);
        tick("to.regrant");
        chk("to.regrant_val", 32'(grant), 32'h80);
        for (int c = 0; c < 15; c++) tick("to.hold2");
        done = 1'b1;
        tick("to.done16");
        chk("to.done_no_pulse", 32'(timeout), 32'd0);
        chk("to.done_rel", 32'(grant), 32'h0);
        done = 1'b0;
        req = 8'h00;
        tick("to.idle1");
        tick("to.idle2");

        // Owner 3 drops request while 6 waits
        req = 8'h48;
        tick("drop.own3");
        chk("drop.own3_id", 32'(grant_id), 32'd3);
        tick("drop.hold");
        req = 8'h40;
        tick("drop.rel");
        chk("drop.zero", 32'(grant), 32'h0);
        tick("drop.next");
        chk("drop.grant6", 32'(grant), 32'h40);
        chk("drop.id6", 32'(grant_id), 32'd6);
        req = 8'h00;
        tick("drop.idle1");
        tick("drop.idle2");

        // Reset in the middle of ownership
        req = 8'h10;
        tick("mid.own4");
        chk("mid.own4_val", 32'(grant), 32'h10);
        #3;
        reset = 1'b1;
        #1;
        chk("mid.async_grant", 32'(grant), 32'h0);
        chk("mid.async_valid", 32'(grant_valid), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick("mid.after");
        chk("mid.regrant", 32'(grant), 32'h10);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            req  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            done = ($urandom_range(0, 4) == 0);
            tick("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
